// File: rtl/wired_inst_buffer_pkg.sv
// Shared frontend/backend types used by the instruction buffer.
// Kept minimal: the instruction package and the backend correction record.
package wired_inst_buffer_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } pipeline_ctrl_pack_t;

  typedef struct packed {
    logic        redirect;
    logic [31:0] target;
  } bpu_correct_t;

endpackage

// File: rtl/wired_inst_buffer_if.sv
// Decoder-to-buffer and buffer-to-rename handshake bundle.
// The buffer uses the slave modport; whoever drives decode/backs the rename stage uses master.
interface wired_inst_buffer_if
  import wired_inst_buffer_pkg::*;
;
  logic                      f_valid;
  logic                      f_ready;
  logic [1:0]                f_mask;
  pipeline_ctrl_pack_t [1:0] f_pkg;

  logic                      pkg_valid;
  logic                      pkg_ready;
  logic [1:0]                pkg_mask;
  pipeline_ctrl_pack_t [1:0] pkg;

  modport master (
    output f_valid, f_mask, f_pkg, pkg_ready,
    input  f_ready, pkg_valid, pkg_mask, pkg
  );

  modport slave (
    input  f_valid, f_mask, f_pkg, pkg_ready,
    output f_ready, pkg_valid, pkg_mask, pkg
  );
endinterface

// File: rtl/wired_inst_buffer_bank.sv
// One bank of instruction storage: a single write port and two asynchronous read rows.
// Contents are intentionally not reset; pointer state alone defines validity.
module wired_inst_buffer_bank
  import wired_inst_buffer_pkg::*;
#(
  parameter int unsigned Rows = 4,
  localparam int unsigned RowW = (Rows > 1) ? $clog2(Rows) : 1
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [RowW-1:0]     wrow_i,
  input  pipeline_ctrl_pack_t wdata_i,
  input  logic [RowW-1:0]     rrow0_i,
  input  logic [RowW-1:0]     rrow1_i,
  output pipeline_ctrl_pack_t rdata0_o,
  output pipeline_ctrl_pack_t rdata1_o
);

  pipeline_ctrl_pack_t mem_q [Rows];
  pipeline_ctrl_pack_t mem_d [Rows];

  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[wrow_i] = wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rdata0_o = mem_q[rrow0_i];
  assign rdata1_o = mem_q[rrow1_i];

endmodule

// File: rtl/wired_inst_buffer.sv
// 2-wide in-order instruction buffer between decode and rename.
// Compacts arbitrary decoder slot masks and emits left-aligned pairs; flushed on redirect.
module wired_inst_buffer
  import wired_inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wired_inst_buffer_if.slave   bus,
  input  bpu_correct_t         bpu_correct_i,
  output logic [PTR_W:0]       count_o
);

  localparam int unsigned Rows = DEPTH / 2;
  localparam int unsigned RowW = PTR_W - 1;

  typedef logic [PTR_W:0]  ptr_t;
  typedef logic [RowW-1:0] row_t;

  ptr_t rptr_q, rptr_d, wptr_q, wptr_d;
  ptr_t count, n_push, n_pop, wptr_p1, rptr_p1;
  logic redirect, w_fire, r_fire, two_avail;

  pipeline_ctrl_pack_t first_pkg, second_pkg;
  logic                b_we    [2];
  row_t                b_wrow  [2];
  pipeline_ctrl_pack_t b_wdata [2];
  pipeline_ctrl_pack_t b_rd0   [2];
  pipeline_ctrl_pack_t b_rd1   [2];
  row_t                rrow0, rrow1, wrow0, wrow1;

  assign redirect  = bpu_correct_i.redirect;
  assign count     = wptr_q - rptr_q;
  assign count_o   = count;
  assign wptr_p1   = wptr_q + ptr_t'(1);
  assign rptr_p1   = rptr_q + ptr_t'(1);

  // Ready depends on pre-pop occupancy only, so no comb path from pkg_ready.
  assign bus.f_ready   = (count <= ptr_t'(DEPTH - 2));
  assign bus.pkg_valid = (count != '0);
  assign two_avail     = (count >= ptr_t'(2));
  assign bus.pkg_mask  = {two_avail, bus.pkg_valid};

  assign w_fire = bus.f_valid & bus.f_ready & ~redirect;
  assign r_fire = bus.pkg_valid & bus.pkg_ready & ~redirect;
  assign n_push = ptr_t'(bus.f_mask[0]) + ptr_t'(bus.f_mask[1]);
  assign n_pop  = two_avail ? ptr_t'(2) : ptr_t'(1);

  // Compaction: the oldest valid slot always lands at wptr, the second (if any) at wptr+1.
  assign first_pkg  = bus.f_mask[0] ? bus.f_pkg[0] : bus.f_pkg[1];
  assign second_pkg = bus.f_pkg[1];
  assign wrow0      = wptr_q[PTR_W-1:1];
  assign wrow1      = wptr_p1[PTR_W-1:1];

  always_comb begin
    b_we[0]    = 1'b0;
    b_we[1]    = 1'b0;
    b_wrow[0]  = wrow0;
    b_wrow[1]  = wrow0;
    b_wdata[0] = first_pkg;
    b_wdata[1] = second_pkg;
    if (!wptr_q[0]) begin
      b_we[0]    = w_fire & (n_push != '0);
      b_we[1]    = w_fire & (&bus.f_mask);
    end else begin
      b_we[1]    = w_fire & (n_push != '0);
      b_wdata[1] = first_pkg;
      b_we[0]    = w_fire & (&bus.f_mask);
      b_wrow[0]  = wrow1;
      b_wdata[0] = second_pkg;
    end
  end

  assign rrow0 = rptr_q[PTR_W-1:1];
  assign rrow1 = rptr_p1[PTR_W-1:1];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    wired_inst_buffer_bank #(
      .Rows (Rows)
    ) u_bank (
      .clk_i    (clk),
      .we_i     (b_we[b]),
      .wrow_i   (b_wrow[b]),
      .wdata_i  (b_wdata[b]),
      .rrow0_i  (rrow0),
      .rrow1_i  (rrow1),
      .rdata0_o (b_rd0[b]),
      .rdata1_o (b_rd1[b])
    );
  end

  // Odd rptr: oldest sits in bank 1, its successor in bank 0 one row further on.
  always_comb begin
    if (!rptr_q[0]) begin
      bus.pkg[0] = b_rd0[0];
      bus.pkg[1] = b_rd0[1];
    end else begin
      bus.pkg[0] = b_rd0[1];
      bus.pkg[1] = b_rd1[0];
    end
  end

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    if (redirect) begin
      rptr_d = '0;
      wptr_d = '0;
    end else begin
      if (w_fire) wptr_d = wptr_q + n_push;
      if (r_fire) rptr_d = rptr_q + n_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr_q <= '0;
      wptr_q <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
    end
  end

  logic unused_sig;
  assign unused_sig = ^{bpu_correct_i.target, wptr_p1[PTR_W], wptr_p1[0],
                        rptr_p1[PTR_W], rptr_p1[0]};

endmodule

// File: tb/tb_wired_inst_buffer.sv
// Directed and randomized-stream checks of the 2-wide instruction buffer.
module tb_wired_inst_buffer;
  import wired_inst_buffer_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] Base = 32'h1C00_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  bpu_correct_t bpu;
  logic [3:0]   count;
  int           n_chk = 0;
  int           n_pass = 0;

  wired_inst_buffer_if bus ();

  wired_inst_buffer #(
    .DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .bpu_correct_i (bpu),
    .count_o       (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic pipeline_ctrl_pack_t mk(input logic [31:0] pc);
    pipeline_ctrl_pack_t p;
    p.pc   = pc;
    p.inst = ~pc;
    return p;
  endfunction

  task automatic push(input logic [1:0] m, input logic [31:0] pc0, input logic [31:0] pc1);
    bus.f_valid  = 1'b1;
    bus.f_mask   = m;
    bus.f_pkg[0] = mk(pc0);
    bus.f_pkg[1] = mk(pc1);
  endtask

  task automatic idle_in();
    bus.f_valid = 1'b0;
    bus.f_mask  = 2'b00;
  endtask

  initial begin
    int          wr;
    int          rd;
    logic        stall;
    logic [1:0]  pm;
    logic [1:0]  m;
    logic [31:0] p0, p1, a;
    int          n;

    rst_n         = 1'b0;
    bpu           = '0;
    bus.pkg_ready = 1'b0;
    bus.f_pkg     = '0;
    idle_in();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("rst_valid", 32'(bus.pkg_valid), 32'd0);
    check("rst_mask", 32'(bus.pkg_mask), 32'd0);
    check("rst_fready", 32'(bus.f_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);

    // Compaction: mask 10 then 11
    push(2'b10, 32'hDEAD_BEEF, Base + 32'h4);
    tick();
    push(2'b11, Base + 32'h8, Base + 32'hC);
    tick();
    idle_in();
    check("cmp_count", 32'(count), 32'd3);
    check("cmp_mask", 32'(bus.pkg_mask), 32'd3);
    check("cmp_pc0", bus.pkg[0].pc, Base + 32'h4);
    check("cmp_pc1", bus.pkg[1].pc, Base + 32'h8);
    bus.pkg_ready = 1'b1;
    tick();
    bus.pkg_ready = 1'b0;
    check("pop_mask", 32'(bus.pkg_mask), 32'd1);
    check("pop_pc0", bus.pkg[0].pc, Base + 32'hC);
    check("pop_count", 32'(count), 32'd1);
    bus.pkg_ready = 1'b1;
    tick();
    bus.pkg_ready = 1'b0;
    check("drain_count", 32'(count), 32'd0);

    // Fill to full
    for (int i = 0; i < 4; i++) begin
      push(2'b11, Base + 32'h100 + 32'(8 * i), Base + 32'h104 + 32'(8 * i));
      tick();
    end
    idle_in();
    check("full_count", 32'(count), 32'd8);
    check("full_fready", 32'(bus.f_ready), 32'd0);
    push(2'b11, Base + 32'h900, Base + 32'h904);
    tick();
    idle_in();
    check("full_hold_count", 32'(count), 32'd8);
    check("full_hold_pc0", bus.pkg[0].pc, Base + 32'h100);
    bus.pkg_ready = 1'b1;
    tick();
    bus.pkg_ready = 1'b0;
    check("after_pop_count", 32'(count), 32'd6);
    check("after_pop_fready", 32'(bus.f_ready), 32'd1);
    check("after_pop_pc0", bus.pkg[0].pc, Base + 32'h108);
    check("after_pop_pc1", bus.pkg[1].pc, Base + 32'h10C);

    // Simultaneous push and pop at count 6, then drain across the wrap
    push(2'b11, Base + 32'h200, Base + 32'h204);
    bus.pkg_ready = 1'b1;
    tick();
    idle_in();
    bus.pkg_ready = 1'b0;
    check("pp_count", 32'(count), 32'd6);
    check("pp_pc0", bus.pkg[0].pc, Base + 32'h110);
    check("pp_pc1", bus.pkg[1].pc, Base + 32'h114);
    bus.pkg_ready = 1'b1;
    tick();
    check("wrap_pc0_a", bus.pkg[0].pc, Base + 32'h118);
    check("wrap_pc1_a", bus.pkg[1].pc, Base + 32'h11C);
    check("wrap_count_a", 32'(count), 32'd4);
    tick();
    check("wrap_pc0_b", bus.pkg[0].pc, Base + 32'h200);
    check("wrap_pc1_b", bus.pkg[1].pc, Base + 32'h204);
    check("wrap_count_b", 32'(count), 32'd2);
    tick();
    bus.pkg_ready = 1'b0;
    check("wrap_empty", 32'(bus.pkg_valid), 32'd0);

    // Redirect at count 5 with concurrent push and pop
    push(2'b11, Base + 32'h300, Base + 32'h304);
    tick();
    push(2'b11, Base + 32'h308, Base + 32'h30C);
    tick();
    push(2'b01, Base + 32'h310, 32'h0);
    tick();
    idle_in();
    check("pre_redir_count", 32'(count), 32'd5);
    push(2'b11, Base + 32'h400, Base + 32'h404);
    bus.pkg_ready = 1'b1;
    bpu.redirect  = 1'b1;
    tick();
    idle_in();
    bus.pkg_ready = 1'b0;
    bpu.redirect  = 1'b0;
    check("redir_count", 32'(count), 32'd0);
    check("redir_valid", 32'(bus.pkg_valid), 32'd0);
    check("redir_fready", 32'(bus.f_ready), 32'd1);
    push(2'b01, Base + 32'h1000, 32'h0);
    tick();
    idle_in();
    check("post_redir_valid", 32'(bus.pkg_valid), 32'd1);
    check("post_redir_mask", 32'(bus.pkg_mask), 32'd1);
    check("post_redir_pc0", bus.pkg[0].pc, Base + 32'h1000);
    bus.pkg_ready = 1'b1;
    tick();
    bus.pkg_ready = 1'b0;
    check("post_redir_drain", 32'(count), 32'd0);

    // Random stream of 200 instructions
    wr    = 0;
    rd    = 0;
    stall = 1'b0;
    pm    = 2'b00;
    p0    = '0;
    p1    = '0;
    for (int cyc = 0; cyc < 3000 && rd < 200; cyc++) begin
      if (stall) begin
        check("stable_pc0", bus.pkg[0].pc, p0);
        if (pm == 2'b11) begin
          check("stable_mask", 32'(bus.pkg_mask), 32'd3);
          check("stable_pc1", bus.pkg[1].pc, p1);
        end
      end
      check("no_mask10", 32'(bus.pkg_mask == 2'b10), 32'd0);
      bus.pkg_ready = ($urandom_range(0, 3) != 0);
      if (bus.pkg_valid && bus.pkg_ready) begin
        check("order0", bus.pkg[0].pc, Base + 32'h2000 + 32'(4 * rd));
        rd++;
        if (bus.pkg_mask == 2'b11) begin
          check("order1", bus.pkg[1].pc, Base + 32'h2000 + 32'(4 * rd));
          rd++;
        end
      end
      stall = bus.pkg_valid && !bus.pkg_ready;
      pm    = bus.pkg_mask;
      p0    = bus.pkg[0].pc;
      p1    = bus.pkg[1].pc;

      if (wr >= 200) begin
        idle_in();
      end else begin
        m = 2'($urandom_range(0, 3));
        if (200 - wr < 2 && m == 2'b11) m = 2'b01;
        a = Base + 32'h2000 + 32'(4 * wr);
        unique case (m)
          2'b11:   push(m, a, a + 32'h4);
          2'b01:   push(m, a, 32'hBAD0_0001);
          2'b10:   push(m, 32'hBAD0_0002, a);
          default: push(m, 32'hBAD0_0003, 32'hBAD0_0004);
        endcase
        bus.f_valid = ($urandom_range(0, 4) != 0);
        n = int'(m[0]) + int'(m[1]);
        if (bus.f_valid && bus.f_ready) wr += n;
      end
      tick();
    end
    idle_in();
    bus.pkg_ready = 1'b0;
    check("rand_rd_done", 32'(rd), 32'd200);
    check("rand_wr_done", 32'(wr), 32'd200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
